// File: rtl/mp_intc_pkg.sv
// mp_intc_pkg -- shared constants for the mp_intc interrupt controller.
//   NUM_SRC   : number of external interrupt lines
//   CODE_SWI  : exception code reported for the software interrupt
//   ADR_*     : register offsets on the cfg_adr bus
package mp_intc_pkg;

    localparam int          NUM_SRC  = 16;
    localparam logic [4:0]  CODE_SWI = 5'd31;

    localparam logic [2:0]  ADR_MVEC    = 3'd0;
    localparam logic [2:0]  ADR_MEPC    = 3'd1;
    localparam logic [2:0]  ADR_ENABLE  = 3'd2;
    localparam logic [2:0]  ADR_PENDING = 3'd3;
    localparam logic [2:0]  ADR_EDGE    = 3'd4;
    localparam logic [2:0]  ADR_STATUS  = 3'd5;

    typedef logic [4:0] code_t;

endpackage

// File: rtl/mp_intc_prio.sv
// mp_intc_prio -- combinational priority picker.
//   req_i   [NUM_SRC:0] : bit NUM_SRC is the software interrupt, the rest are
//                         enabled & pending external sources
//   valid_o             : any request present
//   code_o  [4:0]       : CODE_SWI if the software request is set, otherwise
//                         the lowest requesting index; 0 when nothing requests
module mp_intc_prio
    import mp_intc_pkg::*;
(
    input  logic [NUM_SRC:0] req_i,
    output logic             valid_o,
    output code_t            code_o
);

    always_comb begin
        valid_o = |req_i;
        code_o  = '0;
        // Walk downward so the lowest set index is the last assignment.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                code_o = 5'(i);
            end
        end
        if (req_i[NUM_SRC]) begin
            code_o = CODE_SWI;
        end
    end

endmodule

// File: rtl/mp_intc.sv
// mp_intc -- 16-source interrupt controller with software interrupt.
//   clk, ext_rst (async, active-high)
//   irq_src[15:0]  external lines        swi      software interrupt pulse
//   mie_set        re-enable request     pc_epc   PC captured on take
//   mie, exi, exi_code, mvec, mepc       core-facing status outputs
//   cfg_we/cfg_adr/cfg_wdata/cfg_rdata  register access (combinational read)
// Optional build macro INTC_SYNC_EN: inserts a two-flop synchronizer on
// irq_src, adding two cycles of latency. Without it irq_src must already be
// synchronous to clk.
module mp_intc
    import mp_intc_pkg::*;
(
    input  logic               clk,
    input  logic               ext_rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               swi,
    input  logic               mie_set,
    input  logic [31:0]        pc_epc,
    output logic               mie,
    output logic               exi,
    output logic [4:0]         exi_code,
    output logic [31:0]        mvec,
    output logic [31:0]        mepc,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_adr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata
);

    logic [NUM_SRC-1:0] irq_s;

`ifdef INTC_SYNC_EN
    localparam int ARM_LEN = 3;
    logic [NUM_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge ext_rst) begin
        if (ext_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end
    assign irq_s = sync2_q;
`else
    localparam int ARM_LEN = 1;
    assign irq_s = irq_src;
`endif

    logic [31:0]        mvec_q, mvec_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC:0]   pending_q, pending_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic               mie_q, mie_d;
    code_t              last_code_q, last_code_d;
    logic [NUM_SRC-1:0] hist_q;
    // Edge detection stays masked until the sampling path has been refilled
    // after reset, so a line already high at release is not seen as a rise.
    logic [ARM_LEN-1:0] arm_q;
    logic               armed;

    logic [NUM_SRC:0]   hw_set, w1c, take_clr, req;
    logic               prio_valid;
    code_t              prio_code;
    logic               take;

    assign armed = arm_q[ARM_LEN-1];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign hw_set[gi] = edge_q[gi] ? (irq_s[gi] & ~hist_q[gi] & armed)
                                           : irq_s[gi];
            assign req[gi]    = pending_q[gi] & enable_q[gi];
        end
    endgenerate
    assign hw_set[NUM_SRC] = swi;
    assign req[NUM_SRC]    = pending_q[NUM_SRC];

    mp_intc_prio u_prio (
        .req_i   (req),
        .valid_o (prio_valid),
        .code_o  (prio_code)
    );

    assign exi      = mie_q & prio_valid;
    assign exi_code = exi ? prio_code : 5'd0;
    assign take     = exi;

    logic wr_mvec, wr_mepc, wr_en, wr_pend, wr_edge, wr_stat;
    assign wr_mvec = cfg_we && (cfg_adr == ADR_MVEC);
    assign wr_mepc = cfg_we && (cfg_adr == ADR_MEPC);
    assign wr_en   = cfg_we && (cfg_adr == ADR_ENABLE);
    assign wr_pend = cfg_we && (cfg_adr == ADR_PENDING);
    assign wr_edge = cfg_we && (cfg_adr == ADR_EDGE);
    assign wr_stat = cfg_we && (cfg_adr == ADR_STATUS);

    always_comb begin
        w1c      = wr_pend ? cfg_wdata[NUM_SRC:0] : '0;
        take_clr = '0;
        // Level sources are not cleared by a take; software clears them
        // once the line has dropped.
        if (take) begin
            if (prio_code == CODE_SWI) begin
                take_clr[NUM_SRC] = 1'b1;
            end else if (edge_q[prio_code[3:0]]) begin
                take_clr[prio_code[3:0]] = 1'b1;
            end
        end
        // A fresh hardware set beats a clear in the same cycle.
        pending_d = (pending_q & ~w1c & ~take_clr) | hw_set;

        mvec_d      = wr_mvec ? cfg_wdata : mvec_q;
        enable_d    = wr_en   ? cfg_wdata[NUM_SRC-1:0] : enable_q;
        edge_d      = wr_edge ? cfg_wdata[NUM_SRC-1:0] : edge_q;
        mepc_d      = take ? pc_epc : (wr_mepc ? cfg_wdata : mepc_q);
        last_code_d = take ? prio_code : last_code_q;

        if (take) begin
            mie_d = 1'b0;
        end else if (wr_stat) begin
            mie_d = cfg_wdata[0];
        end else if (mie_set) begin
            mie_d = 1'b1;
        end else begin
            mie_d = mie_q;
        end
    end

    always_ff @(posedge clk or posedge ext_rst) begin
        if (ext_rst) begin
            mvec_q      <= '0;
            mepc_q      <= '0;
            enable_q    <= '0;
            pending_q   <= '0;
            edge_q      <= '0;
            mie_q       <= 1'b0;
            last_code_q <= '0;
            hist_q      <= '0;
            arm_q       <= '0;
        end else begin
            mvec_q      <= mvec_d;
            mepc_q      <= mepc_d;
            enable_q    <= enable_d;
            pending_q   <= pending_d;
            edge_q      <= edge_d;
            mie_q       <= mie_d;
            last_code_q <= last_code_d;
            hist_q      <= irq_s;
            arm_q       <= ARM_LEN'({arm_q, 1'b1});
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_adr)
            ADR_MVEC:    cfg_rdata = mvec_q;
            ADR_MEPC:    cfg_rdata = mepc_q;
            ADR_ENABLE:  cfg_rdata = {16'd0, enable_q};
            ADR_PENDING: cfg_rdata = {15'd0, pending_q};
            ADR_EDGE:    cfg_rdata = {16'd0, edge_q};
            ADR_STATUS:  cfg_rdata = {19'd0, last_code_q, 7'd0, mie_q};
            default:     cfg_rdata = '0;
        endcase
    end

    assign mie  = mie_q;
    assign mvec = mvec_q;
    assign mepc = mepc_q;

endmodule

// File: tb/tb_mp_intc.sv
// tb_mp_intc -- directed self-checking bench for mp_intc (default build).
module tb_mp_intc;
    import mp_intc_pkg::*;

    logic        clk = 1'b0;
    logic        ext_rst;
    logic [15:0] irq_src;
    logic        swi, mie_set;
    logic [31:0] pc_epc;
    logic        mie, exi;
    logic [4:0]  exi_code;
    logic [31:0] mvec, mepc;
    logic        cfg_we;
    logic [2:0]  cfg_adr;
    logic [31:0] cfg_wdata, cfg_rdata;

    int total = 0;
    int bad   = 0;

    mp_intc dut (
        .clk       (clk),
        .ext_rst   (ext_rst),
        .irq_src   (irq_src),
        .swi       (swi),
        .mie_set   (mie_set),
        .pc_epc    (pc_epc),
        .mie       (mie),
        .exi       (exi),
        .exi_code  (exi_code),
        .mvec      (mvec),
        .mepc      (mepc),
        .cfg_we    (cfg_we),
        .cfg_adr   (cfg_adr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] adr, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_adr   = adr;
        cfg_wdata = data;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] adr, input logic [31:0] exp);
        cfg_adr = adr;
        #1;
        chk(tag, cfg_rdata, exp);
    endtask

    initial begin
        ext_rst = 1'b1; irq_src = '0; swi = 1'b0; mie_set = 1'b0; pc_epc = '0;
        cfg_we = 1'b0; cfg_adr = '0; cfg_wdata = '0;
        repeat (3) step();
        chk("rst_exi", 32'(exi), 32'd0);
        chk("rst_mie", 32'(mie), 32'd0);
        chk("rst_mvec", mvec, 32'd0);
        ext_rst = 1'b0;
        step();
        chk("post_rst_code", 32'(exi_code), 32'd0);
        rd_chk("post_rst_status", ADR_STATUS, 32'd0);

        // Edge source 3, single pulse
        wr(ADR_MVEC, 32'h8000_0100);
        chk("mvec_out", mvec, 32'h8000_0100);
        wr(ADR_EDGE, 32'h0008);
        wr(ADR_ENABLE, 32'h0008);
        wr(ADR_STATUS, 32'h1);
        chk("mie_set_by_cfg", 32'(mie), 32'd1);
        pc_epc = 32'h1234;
        irq_src[3] = 1'b1;
        step();
        irq_src[3] = 1'b0;
        chk("t1_exi", 32'(exi), 32'd1);
        chk("t1_code", 32'(exi_code), 32'd3);
        step();
        chk("t1_exi_gone", 32'(exi), 32'd0);
        chk("t1_mepc", mepc, 32'h1234);
        chk("t1_mie", 32'(mie), 32'd0);
        rd_chk("t1_pending", ADR_PENDING, 32'h0);
        rd_chk("t1_status", ADR_STATUS, 32'h0300);

        // Simultaneous rises on 2 and 9
        wr(ADR_EDGE, 32'h0204);
        wr(ADR_ENABLE, 32'h0204);
        wr(ADR_STATUS, 32'h1);
        pc_epc = 32'h2000;
        irq_src[2] = 1'b1; irq_src[9] = 1'b1;
        step();
        irq_src[2] = 1'b0; irq_src[9] = 1'b0;
        chk("t2_exi", 32'(exi), 32'd1);
        chk("t2_code_first", 32'(exi_code), 32'd2);
        step();
        chk("t2_mie_after_take", 32'(mie), 32'd0);
        rd_chk("t2_pending_left", ADR_PENDING, 32'h0200);
        mie_set = 1'b1;
        step();
        mie_set = 1'b0;
        chk("t2_exi_again", 32'(exi), 32'd1);
        chk("t2_code_second", 32'(exi_code), 32'd9);
        step();
        chk("t2_exi_gone", 32'(exi), 32'd0);
        rd_chk("t2_pending_empty", ADR_PENDING, 32'h0);

        // Software interrupt outranks pending source 0
        wr(ADR_EDGE, 32'h0001);
        wr(ADR_ENABLE, 32'h0001);
        irq_src[0] = 1'b1;
        step();
        irq_src[0] = 1'b0;
        chk("t3_no_exi_mie0", 32'(exi), 32'd0);
        chk("t3_code_zero", 32'(exi_code), 32'd0);
        swi = 1'b1;
        step();
        swi = 1'b0;
        mie_set = 1'b1;
        step();
        mie_set = 1'b0;
        chk("t3_exi_swi", 32'(exi), 32'd1);
        chk("t3_code_swi", 32'(exi_code), 32'd31);
        step();
        rd_chk("t3_status_swi", ADR_STATUS, 32'h1F00);
        rd_chk("t3_pending_src0", ADR_PENDING, 32'h0001);
        mie_set = 1'b1;
        step();
        mie_set = 1'b0;
        chk("t3_code_src0", 32'(exi_code), 32'd0);
        chk("t3_exi_src0", 32'(exi), 32'd1);
        step();
        rd_chk("t3_pending_empty", ADR_PENDING, 32'h0);

        // Level source 5 and W1C
        wr(ADR_EDGE, 32'h0000);
        wr(ADR_ENABLE, 32'h0020);
        irq_src[5] = 1'b1;
        step();
        wr(ADR_PENDING, 32'h0020);
        rd_chk("t4_w1c_line_high", ADR_PENDING, 32'h0020);
        irq_src[5] = 1'b0;
        step();
        wr(ADR_PENDING, 32'h0020);
        rd_chk("t4_w1c_line_low", ADR_PENDING, 32'h0);
        wr(ADR_STATUS, 32'h1);
        chk("t4_no_exi", 32'(exi), 32'd0);

        // Pending while masked, enabled via STATUS, then reset mid-pending
        wr(ADR_STATUS, 32'h0);
        wr(ADR_EDGE, 32'h0002);
        wr(ADR_ENABLE, 32'h0002);
        irq_src[1] = 1'b1;
        step();
        irq_src[1] = 1'b0;
        chk("t5_masked", 32'(exi), 32'd0);
        rd_chk("t5_pending", ADR_PENDING, 32'h0002);
        wr(ADR_STATUS, 32'h1);
        chk("t5_exi", 32'(exi), 32'd1);
        chk("t5_code", 32'(exi_code), 32'd1);
        ext_rst = 1'b1;
        #1;
        chk("t5_rst_exi", 32'(exi), 32'd0);
        chk("t5_rst_mvec", mvec, 32'd0);
        chk("t5_rst_mepc", mepc, 32'd0);
        rd_chk("t5_rst_enable", ADR_ENABLE, 32'd0);
        rd_chk("t5_rst_pending", ADR_PENDING, 32'd0);
        rd_chk("t5_rst_edge", ADR_EDGE, 32'd0);
        rd_chk("t5_rst_status", ADR_STATUS, 32'd0);
        step();
        ext_rst = 1'b0;
        step();
        chk("t5_after_rst_exi", 32'(exi), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mp_intc.md
MP_INTC -- requirements
Module: mp_intc

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on posedge.
REQ-002 SHALL have ports: ext_rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: irq_src  in  16  external interrupt lines, one per source 0..15.
REQ-004 SHALL have ports: swi  in  1  software-interrupt pulse from core (ecall issue).
REQ-005 SHALL have ports: mie_set  in  1  core request to re-enable interrupts (mret/wfi).
REQ-006 SHALL have ports: pc_epc  in  32  core PC to save on interrupt take.
REQ-007 SHALL have ports: mie  out  1; exi  out  1; exi_code  out  5; mvec  out  32; mepc  out  32.
REQ-008 SHALL have ports: cfg_we  in  1; cfg_adr  in  3; cfg_wdata  in  32; cfg_rdata  out  32  (register access, combinational read).

Function
REQ-009 SHALL hold registers: MVEC(0), MEPC(1), ENABLE[15:0](2), PENDING[16:0](3, bit16 = swi), EDGE[15:0](4), STATUS(5: bit0 mie rw, bits12:8 last taken code ro); other addresses read 0, writes ignored.
REQ-010 SHALL, per source i, set PENDING[i] on 0->1 of irq_src[i] when EDGE[i]=1, else track irq_src[i] level each cycle.
REQ-011 SHALL set PENDING[16] on any cycle swi=1.
REQ-012 SHALL drive exi = mie & (PENDING[16] | |(PENDING[15:0] & ENABLE)) combinationally from registers.
REQ-013 SHALL drive exi_code = 31 if PENDING[16], else lowest index i with PENDING[i]&ENABLE[i]; 0 when exi=0.
REQ-014 SHALL "take" at every posedge where exi=1: mie<=0, MEPC<=pc_epc, last code<=exi_code, clear taken pending bit if edge-mode or swi; exi therefore high exactly one cycle per take.
REQ-015 SHALL give latency: irq_src rise sampled at edge k -> exi high cycle after k -> take at edge k+1 (plus 2 with REQ-026).
REQ-016 SHALL set mie<=1 on mie_set; mie_set with mie already 1 no effect.
REQ-017 SHALL clear PENDING bits on cfg write of 1 (W1C); level-mode bits with line still high stay set.
REQ-018 SHALL give precedence: hardware set over W1C same cycle; take capture of MEPC over cfg MEPC write; cfg STATUS write over mie_set; take over mie_set (mie ends 0).
REQ-019 SHALL leave disabled pending bits latched; enabling later raises exi next cycle.
REQ-020 SHALL drive mvec/mepc directly from MVEC/MEPC registers.

Reset
REQ-021 SHALL, on ext_rst, asynchronously clear MVEC, MEPC, ENABLE, PENDING, EDGE, mie, last code, edge-detect history.
REQ-022 SHALL drive exi=0, exi_code=0, mie=0, mvec=0, mepc=0 during and after reset until configured.
REQ-023 SHALL drop in-progress edges at reset: line high at release does not set edge-mode pending.

Configuration
REQ-024 SHALL compile two-flop synchronizer on irq_src only when INTC_SYNC_EN defined.
REQ-025 SHALL, without INTC_SYNC_EN, sample irq_src directly (sources synchronous to clk).
REQ-026 SHALL, with INTC_SYNC_EN, add exactly 2 cycles to REQ-015 latency; synchronizer flops reset to 0.

Structure
REQ-027 SHALL place in package mp_intc_pkg: register offsets, NUM_SRC=16, CODE_SWI=5'd31.
REQ-028 SHALL instantiate one sub-module mp_intc_prio: 17-bit request in, valid and 5-bit code out, combinational.

Verification
REQ-029 SHALL cover: EDGE[3]=1, ENABLE=0x0008, mie=1, pc_epc=0x1234, pulse irq_src[3] -> one-cycle exi, exi_code=3, mepc=0x1234, mie=0, PENDING[3]=0.
REQ-030 SHALL cover: irq_src[2] and [9] rise same cycle, both enabled -> code 2 taken; after mie_set code 9 taken.
REQ-031 SHALL cover: swi with irq_src[0] pending -> exi_code=31 first, then 0 after mie_set.
REQ-032 SHALL cover: level source 5 held high, W1C PENDING[5] -> bit stays set; line low then W1C -> bit 0, no exi.
REQ-033 SHALL cover: mie=0, irq_src[1] edge, later STATUS write mie=1 -> exi next cycle; ext_rst mid-pending -> all regs 0, exi 0.
